xspi_os_phy_master: RTL and testbench

Host-side single-clock xSPI/octal-SPI PHY. It drives SCK, CE# and SIO to exercise the bridge's octal-SPI slave PHY from the other end of the link, one transaction segment at a time. Its segment interface mirrors the slave PHY's (`txnbc`/`txnmode`/`txndir`/`txndone`/`txndata`), so a host-side controller FSM can chain command, address, dummy and data segments under one CE# assertion. It is used in loopback benches and FPGA host builds.

---
 rtl/xspi_os_phy_master.sv | 221 ++++++++++++++++++++++
 tb/tb_xspi_os_phy_master.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/xspi_os_phy_master.sv
// Host-side octal-SPI PHY: drives SCK/CE#/SIO one transaction segment at a time.
// Segments chain under a single CE# assertion until one is flagged last.
`timescale 1ns/1ps
module xspi_os_phy_master #(
  parameter int unsigned CYCLE_COUNT_BITS = 6,
  parameter int unsigned CLKDIV           = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        txnstart_i,
  input  logic [CYCLE_COUNT_BITS-1:0] txnbc_i,
  input  logic [1:0]                  txnmode_i,
  input  logic                        txndir_i,
  input  logic                        txnlast_i,
  input  logic [31:0]                 txndata_i,
  output logic                        ready_o,
  output logic                        txndone_o,
  output logic                        txnerr_o,
  output logic [31:0]                 txndata_o,
  output logic                        sck_o,
  output logic                        sce_o,
  output logic [7:0]                  sio_o,
  input  logic [7:0]                  sio_i,
  output logic                        sio_oe_o
);

  localparam int unsigned DIV_W  = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam int unsigned BITS_W = CYCLE_COUNT_BITS + 3;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLKDIV - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOW, S_HIGH, S_WAIT, S_HOLD, S_DESEL
  } state_e;

  state_e                      state_q, state_d;
  logic [DIV_W-1:0]            div_q, div_d;
  logic [CYCLE_COUNT_BITS-1:0] cyc_q, cyc_d;
  logic [31:0]                 shreg_q, shreg_d;
  logic [31:0]                 rdata_q, rdata_d;
  logic [1:0]                  mode_q, mode_d;
  logic                        dir_q, dir_d, last_q, last_d;
  logic                        sck_q, sck_d, sce_q, sce_d, oe_q, oe_d;
  logic                        done_q, done_d, err_q, err_d, ready_q, ready_d;
  logic [7:0]                  sio_q, sio_d;

  // Data leaves MSB-first; within a cycle the higher bit sits on the higher lane.
  function automatic logic [7:0] lanes_out(input logic [31:0] s, input logic [1:0] m);
    case (m)
      2'd0:    return {7'b0, s[31]};
      2'd1:    return {6'b0, s[31:30]};
      2'd2:    return {4'b0, s[31:28]};
      default: return s[31:24];
    endcase
  endfunction

  // x1 reads arrive on lane 1, the wider modes on lanes [w-1:0].
  function automatic logic [7:0] lanes_in(input logic [7:0] p, input logic [1:0] m);
    case (m)
      2'd0:    return {7'b0, p[1]};
      2'd1:    return {6'b0, p[1:0]};
      2'd2:    return {4'b0, p[3:0]};
      default: return p;
    endcase
  endfunction

  function automatic logic [31:0] shift_lanes(input logic [31:0] s, input logic [1:0] m);
    case (m)
      2'd0:    return {s[30:0], 1'b0};
      2'd1:    return {s[29:0], 2'b0};
      2'd2:    return {s[27:0], 4'b0};
      default: return {s[23:0], 8'b0};
    endcase
  endfunction

  logic              accept, reject;
  logic [BITS_W-1:0] req_bits;
  logic [5:0]        lsh;
  logic [31:0]       load_data, sampled;

  assign accept    = txnstart_i && ((state_q == S_IDLE) || (state_q == S_WAIT));
  assign req_bits  = BITS_W'(txnbc_i) << txnmode_i;
  assign reject    = (txnbc_i == '0) || (req_bits > BITS_W'(32));
  assign lsh       = 6'd32 - req_bits[5:0];
  assign load_data = txndata_i << lsh;
  assign sampled   = shift_lanes(shreg_q, mode_q) | {24'b0, lanes_in(sio_i, mode_q)};

  // NOTE: every _d gets its hold value first so no path through the case leaves a latch.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    cyc_d   = cyc_q;
    shreg_d = shreg_q;
    rdata_d = rdata_q;
    mode_d  = mode_q;
    dir_d   = dir_q;
    last_d  = last_q;
    sck_d   = sck_q;
    sce_d   = sce_q;
    oe_d    = oe_q;
    sio_d   = sio_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      S_IDLE, S_WAIT: begin
        if (accept && reject) begin
          err_d = 1'b1;
        end else if (accept) begin
          state_d = S_LOW;
          div_d   = DIV_MAX;
          cyc_d   = txnbc_i;
          mode_d  = txnmode_i;
          dir_d   = txndir_i;
          last_d  = txnlast_i;
          sce_d   = 1'b0;
          if (txndir_i) begin
            shreg_d = '0;
            oe_d    = 1'b0;
            sio_d   = '0;
          end else begin
            shreg_d = shift_lanes(load_data, txnmode_i);
            oe_d    = 1'b1;
            sio_d   = lanes_out(load_data, txnmode_i);
          end
        end
      end
      S_LOW: begin
        if (div_q == '0) begin
          state_d = S_HIGH;
          sck_d   = 1'b1;
          div_d   = DIV_MAX;
        end else begin
          div_d = div_q - DIV_W'(1);
        end
      end
      S_HIGH: begin
        if (div_q == '0) begin
          sck_d = 1'b0;
          div_d = DIV_MAX;
          if (dir_q) shreg_d = sampled;
          if (cyc_q == CYCLE_COUNT_BITS'(1)) begin
            done_d  = 1'b1;
            oe_d    = 1'b0;
            sio_d   = '0;
            state_d = last_q ? S_HOLD : S_WAIT;
            if (dir_q) rdata_d = sampled;
          end else begin
            cyc_d   = cyc_q - CYCLE_COUNT_BITS'(1);
            state_d = S_LOW;
            if (!dir_q) begin
              sio_d   = lanes_out(shreg_q, mode_q);
              shreg_d = shift_lanes(shreg_q, mode_q);
            end
          end
        end else begin
          div_d = div_q - DIV_W'(1);
        end
      end
      S_HOLD: begin
        if (div_q == '0) begin
          state_d = S_DESEL;
          sce_d   = 1'b1;
          div_d   = DIV_MAX;
        end else begin
          div_d = div_q - DIV_W'(1);
        end
      end
      default: begin
        if (div_q == '0) state_d = S_IDLE;
        else             div_d   = div_q - DIV_W'(1);
      end
    endcase
    ready_d = (state_d == S_IDLE) || (state_d == S_WAIT);
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      cyc_q   <= '0;
      shreg_q <= '0;
      rdata_q <= '0;
      mode_q  <= '0;
      dir_q   <= 1'b0;
      last_q  <= 1'b0;
      sck_q   <= 1'b0;
      sce_q   <= 1'b1;
      oe_q    <= 1'b0;
      sio_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      cyc_q   <= cyc_d;
      shreg_q <= shreg_d;
      rdata_q <= rdata_d;
      mode_q  <= mode_d;
      dir_q   <= dir_d;
      last_q  <= last_d;
      sck_q   <= sck_d;
      sce_q   <= sce_d;
      oe_q    <= oe_d;
      sio_q   <= sio_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ready_q <= ready_d;
    end
  end

  assign ready_o   = ready_q;
  assign txndone_o = done_q;
  assign txnerr_o  = err_q;
  assign txndata_o = rdata_q;
  assign sck_o     = sck_q;
  assign sce_o     = sce_q;
  assign sio_o     = sio_q;
  assign sio_oe_o  = oe_q;

endmodule

// File: tb/tb_xspi_os_phy_master.sv
// Scoreboard bench for xspi_os_phy_master: a driver queues expected segments and SCK
// cycles, a monitor plays the device side and checks every rise, done and error pulse.
`timescale 1ns/1ps
module tb_xspi_os_phy_master;
  localparam int  CCB    = 6;
  localparam int  CLKDIV = 2;
  localparam time PERIOD = 10;

  logic clk = 1'b0;
  always #(PERIOD/2) clk = ~clk;

  logic           rst_n, txnstart, txndir, txnlast;
  logic [CCB-1:0] txnbc;
  logic [1:0]     txnmode;
  logic [31:0]    txndata_in;
  logic           ready, done, err, sck, sce, oe;
  logic [31:0]    txndata_out;
  logic [7:0]     sio_out, sio_in;

  xspi_os_phy_master #(.CYCLE_COUNT_BITS(CCB), .CLKDIV(CLKDIV)) dut (
    .clk_i(clk), .rst_ni(rst_n), .txnstart_i(txnstart), .txnbc_i(txnbc),
    .txnmode_i(txnmode), .txndir_i(txndir), .txnlast_i(txnlast),
    .txndata_i(txndata_in), .ready_o(ready), .txndone_o(done), .txnerr_o(err),
    .txndata_o(txndata_out), .sck_o(sck), .sce_o(sce), .sio_o(sio_out),
    .sio_i(sio_in), .sio_oe_o(oe)
  );

  typedef struct {bit is_err; bit rd; bit last; logic [31:0] rdata; time t_done;} exp_t;
  typedef struct {bit rd; logic [7:0] val;} cyc_t;

  exp_t exp_q[$];
  cyc_t cyc_q[$];
  time  sce_q[$];
  int   n_checks = 0, n_errors = 0;
  int   sck_rises = 0, sce_rises = 0, done_cnt = 0, err_cnt = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, got, want, $time);
    end
  endtask

  // Device side and output checker.
  initial begin
    bit   prev_sck, prev_sce;
    exp_t e;
    cyc_t c;
    prev_sck = 1'b0;
    prev_sce = 1'b1;
    sio_in   = '0;
    forever begin
      @(negedge clk);
      if (sck && !prev_sck) begin
        sck_rises++;
        check("sck_rise_expected", 32'(cyc_q.size() != 0), 32'd1);
        check("sce_low_at_rise", 32'(sce), 32'd0);
        if (cyc_q.size() != 0) begin
          c = cyc_q.pop_front();
          if (c.rd) begin
            check("oe_read", 32'(oe), 32'd0);
            sio_in = c.val;
          end else begin
            check("oe_write", 32'(oe), 32'd1);
            check("sio_out", 32'(sio_out), 32'(c.val));
          end
        end
      end
      if (sce && !prev_sce) begin
        sce_rises++;
        if (sce_q.size() != 0) check("sce_rise_time", 32'($time), 32'(sce_q.pop_front()));
      end
      if (err) begin
        err_cnt++;
        check("err_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("err_is_reject", 32'(e.is_err), 32'd1);
        end
      end
      if (done) begin
        done_cnt++;
        check("done_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("done_not_reject", 32'(e.is_err), 32'd0);
          check("done_time", 32'($time), 32'(e.t_done + PERIOD/2));
          check("sck_low_at_done", 32'(sck), 32'd0);
          check("oe_low_at_done", 32'(oe), 32'd0);
          if (e.rd) check("read_data", txndata_out, e.rdata);
          if (e.last) sce_q.push_back($time + CLKDIV*PERIOD);
        end
      end
      prev_sck = sck;
      prev_sce = sce;
    end
  end

  // Reference: a segment moves the low B bits of the word, w bits per SCK cycle, MSB first.
  task automatic issue(input int bc, input int mode, input bit dir, input bit last,
                       input logic [31:0] data, input logic [31:0] dev, input bit hold,
                       output time t_acc);
    int         w, b, budget;
    exp_t       e;
    cyc_t       c;
    logic [63:0] mw, mb;
    logic [7:0] r, v;
    w = 1 << mode;
    b = bc * w;
    budget = 0;
    while (!ready && budget < 1000) begin @(posedge clk); #1; budget++; end
    check("ready_before_start", 32'(ready), 32'd1);
    txnbc = CCB'(bc); txnmode = 2'(mode); txndir = dir; txnlast = last;
    txndata_in = data; txnstart = 1'b1;
    @(posedge clk);
    t_acc    = $time;
    e.is_err = (bc == 0) || (b > 32);
    e.rd     = dir;
    e.last   = last;
    e.rdata  = '0;
    e.t_done = t_acc + 2*CLKDIV*bc*PERIOD;
    if (!e.is_err) begin
      mw = (64'd1 << w) - 64'd1;
      mb = (64'd1 << b) - 64'd1;
      for (int i = 0; i < bc; i++) begin
        c.rd = dir;
        if (dir) begin
          v = 8'((64'(dev) >> (b - (i+1)*w)) & mw);
          r = 8'($urandom);
          if (w == 1) c.val = {r[7:2], v[0], r[0]};
          else        c.val = (r & ~8'(mw)) | v;
        end else begin
          c.val = 8'((64'(data) >> (b - (i+1)*w)) & mw);
        end
        cyc_q.push_back(c);
      end
      if (dir) e.rdata = 32'(64'(dev) & mb);
    end
    exp_q.push_back(e);
    #1;
    if (hold) begin
      budget = 0;
      while (!sce && budget < 1000) begin @(posedge clk); #1; budget++; end
      check("hold_reached_desel", 32'(sce), 32'd1);
    end
    txnstart = 1'b0;
  endtask

  task automatic wait_idle();
    int budget;
    budget = 0;
    while ((exp_q.size() != 0 || !ready || !sce) && budget < 5000) begin
      @(posedge clk); #1; budget++;
    end
    check("idle_reached", 32'(budget < 5000), 32'd1);
    check("cycles_consumed", 32'(cyc_q.size()), 32'd0);
  endtask

  task automatic wait_to(input time t);
    if (t > $time) #(t - $time);
  endtask

  initial begin
    #500000;
    n_errors++;
    $display("FAIL watchdog: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    time t;
    int  b_sck, b_sce, b_done, b_err, budget, mode, w, maxbc, bc;
    bit  last;
    rst_n = 1'b0; txnstart = 1'b0; txnbc = '0; txnmode = '0; txndir = 1'b0;
    txnlast = 1'b0; txndata_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sck", 32'(sck), 32'd0);
    check("rst_sce", 32'(sce), 32'd1);
    check("rst_sio", 32'(sio_out), 32'd0);
    check("rst_oe", 32'(oe), 32'd0);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_rdata", txndata_out, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // x1 write of 0xA5, then CE# and ready release timing
    issue(8, 0, 1'b0, 1'b1, 32'hA5, 32'h0, 1'b0, t);
    wait_to(t + 33*PERIOD + PERIOD/2); check("a5_sce_hold", 32'(sce), 32'd0);
    wait_to(t + 34*PERIOD + PERIOD/2); check("a5_sce_up", 32'(sce), 32'd1);
    wait_to(t + 35*PERIOD + PERIOD/2); check("a5_ready_low", 32'(ready), 32'd0);
    wait_to(t + 36*PERIOD + PERIOD/2); check("a5_ready_up", 32'(ready), 32'd1);
    @(posedge clk); #1;

    // x8 read of 0x12345678
    issue(4, 3, 1'b1, 1'b1, 32'h0, 32'h12345678, 1'b0, t);
    wait_idle();

    // chained segments under one CE#
    b_sck = sck_rises; b_sce = sce_rises; b_done = done_cnt;
    issue(1, 3, 1'b0, 1'b0, 32'hEE, 32'h0, 1'b0, t);
    issue(4, 3, 1'b0, 1'b0, 32'hDEADBEEF, 32'h0, 1'b0, t);
    issue(2, 3, 1'b1, 1'b1, 32'h0, $urandom, 1'b0, t);
    wait_idle();
    check("chain_sck_cycles", 32'(sck_rises - b_sck), 32'd7);
    check("chain_sce_rises", 32'(sce_rises - b_sce), 32'd1);
    check("chain_dones", 32'(done_cnt - b_done), 32'd3);

    // rejected requests
    b_sck = sck_rises; b_err = err_cnt;
    issue(33, 0, 1'b0, 1'b1, $urandom, 32'h0, 1'b0, t);
    issue(0, 0, 1'b0, 1'b1, $urandom, 32'h0, 1'b0, t);
    repeat (4) @(posedge clk);
    #1;
    check("reject_errs", 32'(err_cnt - b_err), 32'd2);
    check("reject_no_sck", 32'(sck_rises - b_sck), 32'd0);
    check("reject_sce", 32'(sce), 32'd1);
    check("reject_ready", 32'(ready), 32'd1);
    check("reject_scoreboard", 32'(exp_q.size()), 32'd0);

    // reset after the third SCK rise of an x4 write
    b_sck = sck_rises;
    issue(6, 2, 1'b0, 1'b1, $urandom, 32'h0, 1'b0, t);
    budget = 0;
    while (sck_rises < b_sck + 3 && budget < 200) begin @(negedge clk); #1; budget++; end
    check("third_rise_seen", 32'(sck_rises - b_sck), 32'd3);
    rst_n = 1'b0;
    exp_q.delete(); cyc_q.delete(); sce_q.delete();
    b_done = done_cnt;
    @(posedge clk); #1;
    check("midrst_sce", 32'(sce), 32'd1);
    check("midrst_sck", 32'(sck), 32'd0);
    check("midrst_oe", 32'(oe), 32'd0);
    check("midrst_sio", 32'(sio_out), 32'd0);
    check("midrst_ready", 32'(ready), 32'd1);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("midrst_no_done", 32'(done_cnt - b_done), 32'd0);
    issue(6, 2, 1'b0, 1'b1, $urandom, 32'h0, 1'b0, t);
    wait_idle();

    // start held high while busy creates no extra segment
    b_done = done_cnt;
    issue(4, 1, 1'b0, 1'b1, $urandom, 32'h0, 1'b1, t);
    wait_idle();
    repeat (4) @(posedge clk);
    #1;
    check("held_start_dones", 32'(done_cnt - b_done), 32'd1);

    // randomized segments
    for (int n = 0; n < 40; n++) begin
      mode  = $urandom_range(0, 3);
      w     = 1 << mode;
      maxbc = 32 / w;
      if (n != 39 && $urandom_range(0, 9) == 0)
        bc = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(maxbc + 1, 63);
      else
        bc = $urandom_range(1, maxbc);
      last = (n == 39) ? 1'b1 : 1'($urandom_range(0, 1));
      issue(bc, mode, 1'($urandom_range(0, 1)), last, $urandom, $urandom, 1'b0, t);
    end
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
